// File: rtl/iiitb_elc_pkg.sv
// Shared types and constants for the elevator controller.
// Holds the FSM state encoding, default floor count and direction codes.
package iiitb_elc_pkg;

  localparam int N_FLOORS_DEF = 8;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

endpackage

// File: rtl/iiitb_elc_onehot_chk.sv
// One-hot checker: flags a vector with exactly one bit set and reports that bit's index.
// Purely combinational; index is 0 when the vector is not one-hot.
module iiitb_elc_onehot_chk #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // One-hot test: non-zero and clearing the lowest set bit leaves nothing
  always_comb begin
    valid = (vec != '0) && ((vec & (vec - N'(1))) == '0);
  end

  // Index of the set bit; only meaningful when valid
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i] && valid) idx = IW'(i);
    end
  end

endmodule

// File: rtl/iiitb_elc.sv
// Elevator controller: one-hot car position stepping one floor per clock toward a latched target.
// Departure takes one edge after the request, then one floor per edge; all outputs registered.
// over_weight freezes motion and keeps the door open; over_time only matters with the door open.
module iiitb_elc
  import iiitb_elc_pkg::*;
#(
  parameter int N_FLOORS = N_FLOORS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] request_floor,
  input  logic [N_FLOORS-1:0] in_current_floor,
  input  logic                over_time,
  input  logic                over_weight,
  output logic                direction,
  output logic [N_FLOORS-1:0] out_current_floor,
  output logic                complete,
  output logic                door_alert,
  output logic                weight_alert
);

  localparam int IW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;

  state_t              state;
  logic [N_FLOORS-1:0] target;

  logic                req_ok;
  logic [IW-1:0]       req_idx;
  logic                cur_ok;
  logic [IW-1:0]       cur_idx;
  logic                in_ok;
  logic [IW-1:0]       in_idx;

  logic [N_FLOORS-1:0] up_next;
  logic [N_FLOORS-1:0] dn_next;
  logic [N_FLOORS-1:0] reset_floor;
  logic                accept;

  iiitb_elc_onehot_chk #(.N(N_FLOORS), .IW(IW)) u_req_chk (
    .vec   (request_floor),
    .valid (req_ok),
    .idx   (req_idx)
  );

  iiitb_elc_onehot_chk #(.N(N_FLOORS), .IW(IW)) u_cur_chk (
    .vec   (out_current_floor),
    .valid (cur_ok),
    .idx   (cur_idx)
  );

  iiitb_elc_onehot_chk #(.N(N_FLOORS), .IW(IW)) u_in_chk (
    .vec   (in_current_floor),
    .valid (in_ok),
    .idx   (in_idx)
  );

  // Next positions, reset start floor and the request acceptance condition
  always_comb begin
    up_next     = out_current_floor << 1;
    dn_next     = out_current_floor >> 1;
    reset_floor = in_ok ? (N_FLOORS'(1) << in_idx) : N_FLOORS'(1);
    accept      = req_ok && cur_ok && (request_floor != out_current_floor) && !over_weight;
  end

  // Controller FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      out_current_floor <= reset_floor;
      target            <= '0;
      direction         <= DOWN;
      complete          <= 1'b0;
      door_alert        <= 1'b0;
      weight_alert      <= 1'b0;
    end else begin
      weight_alert <= over_weight;
      door_alert   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            target    <= request_floor;
            direction <= (req_idx > cur_idx) ? UP : DOWN;
            complete  <= 1'b0;
            state     <= (req_idx > cur_idx) ? MOVE_UP : MOVE_DOWN;
          end
        end
        MOVE_UP: begin
          if (!over_weight) begin
            if (out_current_floor[N_FLOORS-1]) begin
              // Top floor reached without meeting the target: stop rather than wrap
              state <= IDLE;
            end else begin
              out_current_floor <= up_next;
              if (up_next == target) begin
                state    <= DOOR_OPEN;
                complete <= 1'b1;
              end
            end
          end
        end
        MOVE_DOWN: begin
          if (!over_weight) begin
            if (out_current_floor[0]) begin
              // Bottom floor reached without meeting the target: stop rather than wrap
              state <= IDLE;
            end else begin
              out_current_floor <= dn_next;
              if (dn_next == target) begin
                state    <= DOOR_OPEN;
                complete <= 1'b1;
              end
            end
          end
        end
        DOOR_OPEN: begin
          door_alert <= over_time;
          if (!over_time && !over_weight) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iiitb_elc.sv
// Directed self-checking bench for iiitb_elc with 8 floors.
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
module tb_iiitb_elc;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] request_floor;
  logic [7:0] in_current_floor;
  logic       over_time;
  logic       over_weight;
  logic       direction;
  logic [7:0] out_current_floor;
  logic       complete;
  logic       door_alert;
  logic       weight_alert;

  int checks   = 0;
  int failures = 0;

  iiitb_elc #(.N_FLOORS(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .request_floor     (request_floor),
    .in_current_floor  (in_current_floor),
    .over_time         (over_time),
    .over_weight       (over_weight),
    .direction         (direction),
    .out_current_floor (out_current_floor),
    .complete          (complete),
    .door_alert        (door_alert),
    .weight_alert      (weight_alert)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_floor;

    // ---- Reset with start floor 0x80, request floor 0 ----
    reset = 1'b1; in_current_floor = 8'h80; request_floor = 8'h01;
    over_time = 1'b0; over_weight = 1'b0;
    tick(); tick();
    chk8("rst_floor", out_current_floor, 8'h80);
    chk1("rst_dir", direction, 1'b0);
    chk1("rst_complete", complete, 1'b0);
    chk1("rst_door_alert", door_alert, 1'b0);
    chk1("rst_weight_alert", weight_alert, 1'b0);

    // ---- Trip 0x80 -> 0x01 ----
    reset = 1'b0;
    tick();
    chk8("dn_e1_floor", out_current_floor, 8'h80);
    chk1("dn_e1_dir", direction, 1'b0);
    chk1("dn_e1_complete", complete, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      exp_floor = 8'h80 >> (k - 1);
      chk8("dn_floor", out_current_floor, exp_floor);
      chk1("dn_complete", complete, (k == 8));
    end
    // Door closes, then a request equal to the current floor is ignored
    tick(); tick();
    chk8("same_req_floor", out_current_floor, 8'h01);
    chk1("same_req_complete", complete, 1'b1);

    // ---- Trip 0x01 -> 0x10 ----
    reset = 1'b1; in_current_floor = 8'h01; request_floor = 8'h10;
    tick();
    chk8("rst2_floor", out_current_floor, 8'h01);
    chk1("rst2_complete", complete, 1'b0);
    reset = 1'b0;
    tick();
    chk1("up_e1_dir", direction, 1'b1);
    chk8("up_e1_floor", out_current_floor, 8'h01);
    for (int k = 2; k <= 5; k++) begin
      tick();
      exp_floor = 8'h01 << (k - 1);
      chk8("up_floor", out_current_floor, exp_floor);
      chk1("up_complete", complete, (k == 5));
    end

    // ---- Door held open by over_time, new request pending ----
    over_time = 1'b1; request_floor = 8'h04;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("door_alert_on", door_alert, 1'b1);
      chk1("door_hold_complete", complete, 1'b1);
      chk8("door_hold_floor", out_current_floor, 8'h10);
    end
    over_time = 1'b0;
    tick();
    chk1("door_alert_off", door_alert, 1'b0);
    chk1("door_idle_complete", complete, 1'b1);
    tick();
    chk1("depart2_complete", complete, 1'b0);
    chk1("depart2_dir", direction, 1'b0);
    chk8("depart2_floor", out_current_floor, 8'h10);
    tick();
    chk8("dn2_floor_a", out_current_floor, 8'h08);
    tick();
    chk8("dn2_floor_b", out_current_floor, 8'h04);
    chk1("dn2_complete", complete, 1'b1);

    // ---- Overload mid-trip 0x04 -> 0x80, over_time ignored while moving ----
    request_floor = 8'h80;
    tick();
    tick();
    chk1("up3_dir", direction, 1'b1);
    chk1("up3_complete", complete, 1'b0);
    chk8("up3_depart_floor", out_current_floor, 8'h04);
    tick();
    chk8("up3_floor_a", out_current_floor, 8'h08);
    over_weight = 1'b1; over_time = 1'b1;
    tick();
    chk8("ow_hold1_floor", out_current_floor, 8'h08);
    chk1("ow_hold1_walert", weight_alert, 1'b1);
    chk1("ow_hold1_dalert", door_alert, 1'b0);
    tick();
    chk8("ow_hold2_floor", out_current_floor, 8'h08);
    chk1("ow_hold2_walert", weight_alert, 1'b1);
    over_weight = 1'b0; over_time = 1'b0;
    tick();
    chk8("ow_resume_floor", out_current_floor, 8'h10);
    chk1("ow_resume_walert", weight_alert, 1'b0);
    tick(); tick(); tick();
    chk8("up3_arrive_floor", out_current_floor, 8'h80);
    chk1("up3_arrive_complete", complete, 1'b1);

    // ---- Invalid requests in IDLE ----
    tick();
    request_floor = 8'h00;
    tick(); tick();
    chk8("zero_req_floor", out_current_floor, 8'h80);
    chk1("zero_req_complete", complete, 1'b1);
    request_floor = 8'h11;
    tick(); tick();
    chk8("multi_req_floor", out_current_floor, 8'h80);
    chk1("multi_req_complete", complete, 1'b1);
    chk1("multi_req_dir", direction, 1'b1);

    // ---- Overload blocks departure from IDLE ----
    request_floor = 8'h01; over_weight = 1'b1;
    tick();
    chk1("ow_idle_complete", complete, 1'b1);
    chk1("ow_idle_walert", weight_alert, 1'b1);
    over_weight = 1'b0;
    tick();
    chk1("ow_idle_depart_complete", complete, 1'b0);
    chk1("ow_idle_depart_dir", direction, 1'b0);
    tick();
    chk8("dn4_floor_a", out_current_floor, 8'h40);
    tick();
    chk8("dn4_floor_b", out_current_floor, 8'h20);

    // ---- Reset mid-trip reloads start floor; non-one-hot start falls back to floor 0 ----
    reset = 1'b1; in_current_floor = 8'h08;
    tick();
    chk8("midrst_floor", out_current_floor, 8'h08);
    chk1("midrst_complete", complete, 1'b0);
    chk1("midrst_dir", direction, 1'b0);
    in_current_floor = 8'h06;
    tick();
    chk8("badstart_floor", out_current_floor, 8'h01);
    reset = 1'b0;
    tick(); tick();
    chk8("post_rst_same_floor", out_current_floor, 8'h01);
    chk1("post_rst_complete", complete, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
